// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Optional TX-done interrupt and CTRL.IRQ_EN under `MIRISCV_UART_IRQ_EN.
module miriscv_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        tx_o
`ifdef MIRISCV_UART_IRQ_EN
   ,output logic        irq_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_en;
    logic        rd_en;

    assign hit    = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign offset = data_addr_i[3:2];
    assign wr_en  = hit && data_we_i;
    assign rd_en  = hit && !data_we_i;

    logic        unused_bits;
    assign unused_bits = ^{data_addr_i[1:0], data_wdata_i[31:16], data_be_i[3:2]};

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;
    logic [7:0]  level8;
    logic        empty;
    logic        full;
    logic [7:0]  head;

    assign level  = wr_ptr - rd_ptr;
    assign level8 = 8'(level);
    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(FIFO_DEPTH));
    assign head   = mem[rd_ptr[AW-1:0]];

    state_t      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [15:0] divisor;
    logic [15:0] reload;
    logic        ovf;
    logic        bit_end;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        busy;

    // A zero divisor still yields one-cycle bits.
    assign reload   = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign bit_end  = (bit_cnt == 16'd0);
    assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
    assign push_req = wr_en && (offset == 2'd0) && data_be_i[0];
    assign push     = push_req && (!full || pop);
    assign busy     = !empty || (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf     <= 1'b0;
            divisor <= DEFAULT_DIV;
        end else begin
            if (push_req && !push) begin
                ovf <= 1'b1;
            end else if (wr_en && offset == 2'd1 && data_be_i[0] && data_wdata_i[3]) begin
                ovf <= 1'b0;
            end
            if (wr_en && offset == 2'd2) begin
                if (data_be_i[0]) divisor[7:0]  <= data_wdata_i[7:0];
                if (data_be_i[1]) divisor[15:8] <= data_wdata_i[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_o    <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        state   <= S_START;
                        shreg   <= head;
                        bit_cnt <= reload;
                        tx_o    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        tx_o    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        bit_cnt <= reload;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= reload;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (pop) begin
                            state   <= S_START;
                            shreg   <= head;
                            bit_cnt <= reload;
                            tx_o    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

    logic [31:0] ctrl_rd;

`ifdef MIRISCV_UART_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr_en && offset == 2'd3 && data_be_i[0]) begin
                irq_en <= data_wdata_i[0];
            end
            irq_o <= irq_en && empty && (state == S_IDLE);
        end
    end

    assign ctrl_rd = {31'b0, irq_en};
`else
    assign ctrl_rd = 32'b0;
`endif

    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'b0;
        unique case (offset)
            2'd0: rd_val = 32'b0;
            2'd1: rd_val = {16'b0, level8, 4'b0, ovf, empty, full, busy};
            2'd2: rd_val = {16'b0, divisor};
            2'd3: rd_val = ctrl_rd;
            default: rd_val = 32'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_rdata_o <= 32'b0;
        end else if (rd_en) begin
            data_rdata_o <= rd_val;
        end
    end

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Bench for miriscv_uart_tx: cycle-level line model plus directed literal checks.
// Builds with or without MIRISCV_UART_IRQ_EN.
module tb_miriscv_uart_tx;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] A_TX   = 32'h0000_0100;
    localparam logic [31:0] A_STAT = 32'h0000_0104;
    localparam logic [31:0] A_DIV  = 32'h0000_0108;
    localparam logic [31:0] A_CTRL = 32'h0000_010C;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
`ifdef MIRISCV_UART_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    miriscv_uart_tx dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .data_req_i   (req),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .tx_o         (tx)
`ifdef MIRISCV_UART_IRQ_EN
       ,.irq_o        (irq)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Model: the line is a queue of per-cycle tx levels; the FIFO is a byte queue.
    logic        line_q[$];
    logic [7:0]  mq[$];
    logic [15:0] m_div;
    logic        m_ovf;
    logic [31:0] m_rdata;
    logic        m_irq_en;
    logic        m_irq;
    int          lvl;
    int          eff;
    logic        m_busy;
    logic [7:0]  b;
    logic        v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q.delete();
            mq.delete();
            m_div    = 16'd868;
            m_ovf    = 1'b0;
            m_rdata  = 32'h0;
            m_irq_en = 1'b0;
            m_irq    = 1'b0;
        end else begin
            lvl    = mq.size();
            m_busy = (line_q.size() != 0) || (lvl != 0);
            if (req && !we && addr[31:4] == A_TX[31:4]) begin
                case (addr[3:2])
                    2'd1: m_rdata = {16'h0, 8'(lvl), 4'h0, m_ovf, 1'(lvl == 0), 1'(lvl == DEPTH), m_busy};
                    2'd2: m_rdata = {16'h0, m_div};
`ifdef MIRISCV_UART_IRQ_EN
                    2'd3: m_rdata = {31'h0, m_irq_en};
`endif
                    default: m_rdata = 32'h0;
                endcase
            end
            m_irq = m_irq_en && (lvl == 0) && (line_q.size() == 0);
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && mq.size() != 0) begin
                b   = mq.pop_front();
                eff = (m_div == 16'd0) ? 1 : int'(m_div);
                for (int k = 0; k < 10; k++) begin
                    v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    for (int c = 0; c < eff; c++) line_q.push_back(v);
                end
            end
            if (req && we && addr[31:4] == A_TX[31:4]) begin
                case (addr[3:2])
                    2'd0: if (be[0]) begin
                        if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd1: if (be[0] && wdata[3]) m_ovf = 1'b0;
                    2'd2: begin
                        if (be[0]) m_div[7:0]  = wdata[7:0];
                        if (be[1]) m_div[15:8] = wdata[15:8];
                    end
                    default: begin
`ifdef MIRISCV_UART_IRQ_EN
                        if (be[0]) m_irq_en = wdata[0];
`endif
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("tx_line", 32'(tx), 32'((line_q.size() != 0) ? line_q[0] : 1'b1));
            check("rdata", rdata, m_rdata);
`ifdef MIRISCV_UART_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = e;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a; be = 4'h0;
        @(posedge clk); #1;
        req = 1'b0;
        d = rdata;
    endtask

    task automatic wait_idle(input int limit);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < limit; i++) begin
            rd(A_STAT, s);
            if (!s[0]) break;
        end
        check("idle_timeout", 32'(s[0]), 32'h0);
    endtask

    logic [31:0] d;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rd(A_STAT, d); check("rst_status", d, 32'h0000_0004);
        rd(A_DIV, d);  check("rst_div", d, 32'h0000_0364);
        rd(A_CTRL, d); check("rst_ctrl", d, 32'h0);
        rd(A_TX, d);   check("txdata_rd", d, 32'h0);

        wr(A_DIV, 32'h0000_0012, 4'b0001);
        rd(A_DIV, d);  check("div_be0", d, 32'h0000_0312);
        wr(A_DIV, 32'hABCD_0004, 4'b0011);
        rd(A_DIV, d);  check("div_4", d, 32'h0000_0004);
        rd(32'h0000_0200, d); check("nohit_rd_hold", d, 32'h0000_0004);
        wr(32'h0000_0208, 32'h9, 4'b0011);
        rd(A_DIV, d);  check("nohit_wr", d, 32'h0000_0004);

        wr(A_TX, 32'h55, 4'b0001);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b55_bit%0d", i), 32'(tx), 32'(i % 2));
            repeat (4) @(posedge clk);
            #1;
        end
        check("b55_idle", 32'(tx), 32'h1);
        rd(A_STAT, d); check("b55_done", d, 32'h0000_0004);

        wr(A_TX, 32'h41, 4'b0001);
        wr(A_TX, 32'h42, 4'b0001);
        rd(A_STAT, d); check("two_lvl1", d, 32'h0000_0101);
        wait_idle(200);
        check("two_empty", d, 32'h0000_0101);
        rd(A_STAT, d); check("two_done", d, 32'h0000_0004);

        wr(A_DIV, 32'h0, 4'b0011);
        rd(A_DIV, d);  check("div_0", d, 32'h0);
        wr(A_TX, 32'hA5, 4'b0001);
        wait_idle(40);

`ifdef MIRISCV_UART_IRQ_EN
        wr(A_DIV, 32'h2, 4'b0011);
        wr(A_CTRL, 32'h1, 4'b0001);
        @(posedge clk); #1;
        check("irq_idle", 32'(irq), 32'h1);
        wr(A_TX, 32'h3C, 4'b0001);
        @(posedge clk); #1;
        check("irq_fall", 32'(irq), 32'h0);
        wait_idle(60);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'h1);
`endif

        wr(A_DIV, 32'd868, 4'b0011);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(i * 3), 4'b0001);
        rd(A_STAT, d); check("full", d, 32'h0000_0803);
        wr(A_TX, 32'hEE, 4'b0001);
        rd(A_STAT, d); check("ovf_set", d, 32'h0000_080B);
        wr(A_STAT, 32'h8, 4'b0001);
        rd(A_STAT, d); check("ovf_clr", d, 32'h0000_0803);

        repeat (1000) @(posedge clk);
        #3;
        check("pre_rst_data", 32'(tx), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_high", 32'(tx), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(A_STAT, d); check("post_rst_status", d, 32'h0000_0004);
        rd(A_DIV, d);  check("post_rst_div", d, 32'h0000_0364);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
